// File: rtl/id_issue_stage_pkg.sv
// Shared constants for the decode/issue stage: instruction field positions,
// register-index width and the supported load-latency range.
package id_issue_stage_pkg;

  localparam int REG_W = 5;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 3;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int IMM_W = 16;

  // Keeps an out-of-range LOAD_LAT from building a zero-length or oversized pipe.
  function automatic int clamp_lat(input int lat);
    if (lat < LOAD_LAT_MIN) return LOAD_LAT_MIN;
    if (lat > LOAD_LAT_MAX) return LOAD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/id_issue_stage_load_use_tracker.sv
// Pending-load pipe and load-use hazard match. Entry 0 tracks the instruction
// now in EX; older loads move toward entry LAT-1 and drop off once their data
// is forwardable.
module load_use_tracker
  import id_issue_stage_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hold,
  input  logic             push_v,
  input  logic [REG_W-1:0] push_reg,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  output logic             hit
);

  logic [LAT-1:0]   pend_v;
  logic [REG_W-1:0] pend_reg [LAT];

  // Pipe update: flush clears, hold freezes, otherwise shift and load entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        pend_v[k]   <= 1'b0;
        pend_reg[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < LAT; k++) begin
        pend_v[k]   <= 1'b0;
        pend_reg[k] <= '0;
      end
    end else if (!hold) begin
      for (int k = LAT - 1; k > 0; k--) begin
        pend_v[k]   <= pend_v[k-1];
        pend_reg[k] <= pend_reg[k-1];
      end
      pend_v[0]   <= push_v;
      pend_reg[0] <= push_reg;
    end
  end

  // Any live pending load whose destination is a source actually read; $0 never matches.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      if (pend_v[k] && (pend_reg[k] != '0) &&
          ((uses_rs && (pend_reg[k] == rs)) || (uses_rt && (pend_reg[k] == rt)))) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_issue_stage.sv
// ID/EX issue register with load-use stall detection. Edge priority is
// flush_id > ex_hold > stall (bubble) > advance. stall is combinational and is
// forced low while flush_id is high, since a squashed instruction never waits.
module id_issue_stage
  import id_issue_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 24,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_instr,
  input  logic [DATA_W-1:0] if_id_pc_next,
  input  logic [CTRL_W-1:0] ctrl_bus,
  input  logic              ctrl_is_load,
  input  logic              ctrl_uses_rs,
  input  logic              ctrl_uses_rt,
  input  logic              ctrl_zero_ext,
  input  logic              flush_id,
  input  logic              ex_hold,
  output logic              id_ex_valid,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd,
  output logic [4:0]        id_ex_shamt,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [DATA_W-1:0] id_ex_pc_next,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_is_load,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int LAT = clamp_lat(LOAD_LAT);

  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  shamt;
  logic [IMM_W-1:0]  imm16;
  logic [DATA_W-1:0] imm_ext;
  logic              hit;
  logic              issue;
  logic              push_v;
  logic              unused_opcode;

  assign rs    = if_id_instr[RS_HI:RS_LO];
  assign rt    = if_id_instr[RT_HI:RT_LO];
  assign rd    = if_id_instr[RD_HI:RD_LO];
  assign shamt = if_id_instr[SH_HI:SH_LO];
  assign imm16 = if_id_instr[IMM_HI:IMM_LO];
  // The opcode is consumed by the decoder upstream; only ctrl_bus matters here.
  assign unused_opcode = ^if_id_instr[31:26];

  assign imm_ext = ctrl_zero_ext ? {{(DATA_W-IMM_W){1'b0}}, imm16}
                                 : {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};

  assign stall  = if_id_valid & hit & ~flush_id;
  assign issue  = if_id_valid & ~stall;
  // Loads to $0 never produce a hazard, so they are not tracked at all.
  assign push_v = issue & ctrl_is_load & (rt != '0);

  load_use_tracker #(.LAT(LAT)) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_id),
    .hold     (ex_hold),
    .push_v   (push_v),
    .push_reg (rt),
    .rs       (rs),
    .rt       (rt),
    .uses_rs  (ctrl_uses_rs),
    .uses_rt  (ctrl_uses_rt),
    .hit      (hit)
  );

  // ID/EX register: flush and stall both leave an all-zero bubble; hold freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || (rst_n && flush_id)) begin
      id_ex_valid   <= 1'b0;
      id_ex_rs      <= '0;
      id_ex_rt      <= '0;
      id_ex_rd      <= '0;
      id_ex_shamt   <= '0;
      id_ex_imm     <= '0;
      id_ex_pc_next <= '0;
      id_ex_ctrl    <= '0;
      id_ex_is_load <= 1'b0;
    end else if (!ex_hold) begin
      if (stall) begin
        id_ex_valid   <= 1'b0;
        id_ex_rs      <= '0;
        id_ex_rt      <= '0;
        id_ex_rd      <= '0;
        id_ex_shamt   <= '0;
        id_ex_imm     <= '0;
        id_ex_pc_next <= '0;
        id_ex_ctrl    <= '0;
        id_ex_is_load <= 1'b0;
      end else begin
        id_ex_valid   <= if_id_valid;
        id_ex_rs      <= rs;
        id_ex_rt      <= rt;
        id_ex_rd      <= rd;
        id_ex_shamt   <= shamt;
        id_ex_imm     <= imm_ext;
        id_ex_pc_next <= if_id_pc_next;
        id_ex_ctrl    <= if_id_valid ? ctrl_bus : '0;
        id_ex_is_load <= if_id_valid & ctrl_is_load;
      end
    end
  end

  // Counts bubbles actually inserted; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && !flush_id && !ex_hold && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage. Three instances share one stimulus stream:
// g_dut[0] LOAD_LAT=1/CNT_W=16, g_dut[1] LOAD_LAT=2/CNT_W=16,
// g_dut[2] LOAD_LAT=3/CNT_W=2. Each scenario resets and checks one instance.
module tb_id_issue_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [23:0] ctrl;
    logic        is_load;
  } out_t;

  localparam int OUT_W = $bits(out_t);

  typedef enum int {ADV, BUB, HOLD} kind_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_next;
  logic [23:0] ctrl_bus;
  logic        ctrl_is_load;
  logic        ctrl_uses_rs;
  logic        ctrl_uses_rt;
  logic        ctrl_zero_ext;
  logic        flush_id;
  logic        ex_hold;

  // ---------------- per-instance outputs ----------------
  logic        o_valid   [3];
  logic [4:0]  o_rs      [3];
  logic [4:0]  o_rt      [3];
  logic [4:0]  o_rd      [3];
  logic [4:0]  o_shamt   [3];
  logic [31:0] o_imm     [3];
  logic [31:0] o_pc      [3];
  logic [23:0] o_ctrl    [3];
  logic        o_is_load [3];
  logic        o_stall   [3];
  logic [15:0] o_cnt     [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 3;
    localparam int CW  = (g == 2) ? 2 : 16;
    logic [CW-1:0] cnt;
    id_issue_stage #(.DATA_W(32), .CTRL_W(24), .LOAD_LAT(LAT), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_id_valid   (if_id_valid),
      .if_id_instr   (if_id_instr),
      .if_id_pc_next (if_id_pc_next),
      .ctrl_bus      (ctrl_bus),
      .ctrl_is_load  (ctrl_is_load),
      .ctrl_uses_rs  (ctrl_uses_rs),
      .ctrl_uses_rt  (ctrl_uses_rt),
      .ctrl_zero_ext (ctrl_zero_ext),
      .flush_id      (flush_id),
      .ex_hold       (ex_hold),
      .id_ex_valid   (o_valid[g]),
      .id_ex_rs      (o_rs[g]),
      .id_ex_rt      (o_rt[g]),
      .id_ex_rd      (o_rd[g]),
      .id_ex_shamt   (o_shamt[g]),
      .id_ex_imm     (o_imm[g]),
      .id_ex_pc_next (o_pc[g]),
      .id_ex_ctrl    (o_ctrl[g]),
      .id_ex_is_load (o_is_load[g]),
      .stall         (o_stall[g]),
      .stall_count   (cnt)
    );
    assign o_cnt[g] = 16'(cnt);
  end

  int   sel;
  out_t sel_out;

  always_comb begin
    sel_out = '0;
    sel_out = '{valid: o_valid[sel], rs: o_rs[sel], rt: o_rt[sel], rd: o_rd[sel],
                shamt: o_shamt[sel], imm: o_imm[sel], pc: o_pc[sel],
                ctrl: o_ctrl[sel], is_load: o_is_load[sel]};
  end

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  out_t             last_exp;
  int               checks   = 0;
  int               failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_lw(input int rt, input int rs, input logic [15:0] imm);
    return {6'h23, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    if_id_valid   = 1'b0;
    if_id_instr   = '0;
    if_id_pc_next = '0;
    ctrl_bus      = '0;
    ctrl_is_load  = 1'b0;
    ctrl_uses_rs  = 1'b0;
    ctrl_uses_rt  = 1'b0;
    ctrl_zero_ext = 1'b0;
    flush_id      = 1'b0;
    ex_hold       = 1'b0;
  endtask

  task automatic drive(input logic [31:0] instr, input logic is_load, input logic uses_rs,
                       input logic uses_rt, input logic zext, input logic flush,
                       input logic hold);
    if_id_valid   = 1'b1;
    if_id_instr   = instr;
    if_id_pc_next = $urandom_range(32'h0000_0004, 32'hFFFF_FFFC);
    ctrl_bus      = 24'($urandom_range(1, 24'hFF_FFFF));
    ctrl_is_load  = is_load;
    ctrl_uses_rs  = uses_rs;
    ctrl_uses_rt  = uses_rt;
    ctrl_zero_ext = zext;
    flush_id      = flush;
    ex_hold       = hold;
  endtask

  // One clock step from posedge+1: push the expected ID/EX contents, check the
  // combinational stall mid-cycle, then pop/compare after the edge.
  task automatic step(input string tag, input kind_t kind, input logic exp_stall);
    out_t e;
    logic [OUT_W-1:0] got;
    e = '0;
    case (kind)
      ADV: begin
        e.valid   = if_id_valid;
        e.rs      = if_id_instr[25:21];
        e.rt      = if_id_instr[20:16];
        e.rd      = if_id_instr[15:11];
        e.shamt   = if_id_instr[10:6];
        e.imm     = ctrl_zero_ext ? {16'h0000, if_id_instr[15:0]}
                                  : {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        e.pc      = if_id_pc_next;
        e.ctrl    = if_id_valid ? ctrl_bus : 24'h0;
        e.is_load = if_id_valid & ctrl_is_load;
      end
      HOLD:    e = last_exp;
      default: e = '0;
    endcase
    exp_q.push_back(e);
    last_exp = e;
    @(negedge clk);
    check({tag, "_stall"}, 128'(o_stall[sel]), 128'(exp_stall));
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({tag, "_out"}, 128'(sel_out), 128'(got));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle();
    #1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_rst_out"}, 128'(sel_out), 128'(0));
    check({tag, "_rst_stall"}, 128'(o_stall[sel]), 128'(0));
    check({tag, "_rst_cnt"}, 128'(o_cnt[sel]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    last_exp = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sel = 0;
    rst_n = 1'b0;
    idle();
    last_exp = '0;

    // LOAD_LAT=1: one bubble, then the dependent add issues.
    sel = 0;
    do_reset("s1");
    drive(enc_lw(8, 1, 16'h0010), 1, 1, 0, 0, 0, 0);
    step("s1_lw", ADV, 0);
    drive(enc_add(9, 8, 1), 0, 1, 1, 0, 0, 0);
    step("s1_add_bubble", BUB, 1);
    step("s1_add_issue", ADV, 0);
    check("s1_cnt", 128'(o_cnt[sel]), 128'(1));

    // LOAD_LAT=2: dependent back-to-back gives two bubbles; one gap gives one.
    sel = 1;
    do_reset("s2");
    drive(enc_lw(8, 1, 16'h0020), 1, 1, 0, 0, 0, 0);
    step("s2_lw", ADV, 0);
    drive(enc_add(9, 8, 1), 0, 1, 1, 0, 0, 0);
    step("s2_bub1", BUB, 1);
    step("s2_bub2", BUB, 1);
    step("s2_issue", ADV, 0);
    check("s2_cnt_a", 128'(o_cnt[sel]), 128'(2));
    drive(enc_lw(8, 1, 16'h0024), 1, 1, 0, 0, 0, 0);
    step("s2_lw2", ADV, 0);
    drive(enc_add(10, 2, 3), 0, 1, 1, 0, 0, 0);
    step("s2_indep", ADV, 0);
    drive(enc_add(9, 1, 8), 0, 1, 1, 0, 0, 0);
    step("s2_gap_bub", BUB, 1);
    step("s2_gap_issue", ADV, 0);
    check("s2_cnt_b", 128'(o_cnt[sel]), 128'(3));

    // $0 destination and an unread rt never stall.
    sel = 0;
    do_reset("s3");
    drive(enc_lw(0, 1, 16'h0004), 1, 1, 0, 0, 0, 0);
    step("s3_lw0", ADV, 0);
    drive(enc_add(9, 0, 0), 0, 1, 1, 0, 0, 0);
    step("s3_use0", ADV, 0);
    drive(enc_lw(8, 1, 16'h0008), 1, 1, 0, 0, 0, 0);
    step("s3_lw8", ADV, 0);
    drive(enc_add(10, 2, 8), 0, 1, 0, 0, 0, 0);
    step("s3_rt_unused", ADV, 0);
    check("s3_cnt", 128'(o_cnt[sel]), 128'(0));

    // Stall together with ex_hold: everything frozen, count unchanged.
    sel = 0;
    do_reset("s4");
    drive(enc_lw(8, 1, 16'h0030), 1, 1, 0, 0, 0, 0);
    step("s4_lw", ADV, 0);
    drive(enc_add(9, 8, 1), 0, 1, 1, 0, 0, 1);
    step("s4_hold", HOLD, 1);
    check("s4_cnt_hold", 128'(o_cnt[sel]), 128'(0));
    drive(enc_add(9, 8, 1), 0, 1, 1, 0, 0, 0);
    step("s4_bub", BUB, 1);
    step("s4_issue", ADV, 0);
    check("s4_cnt", 128'(o_cnt[sel]), 128'(1));

    // Flush with a pending hazard (LOAD_LAT=2): stall gated, outputs and pipe cleared.
    sel = 1;
    do_reset("s5");
    drive(enc_lw(8, 1, 16'h0040), 1, 1, 0, 0, 0, 0);
    step("s5_lw", ADV, 0);
    drive(enc_add(9, 8, 1), 0, 1, 1, 0, 1, 0);
    step("s5_flush", BUB, 0);
    drive(enc_add(9, 8, 1), 0, 1, 1, 0, 0, 0);
    step("s5_after", ADV, 0);
    check("s5_cnt", 128'(o_cnt[sel]), 128'(0));

    // Immediate extension of 0x8000.
    sel = 0;
    do_reset("s6");
    drive({6'h08, 5'd2, 5'd3, 16'h8000}, 0, 1, 0, 0, 0, 0);
    step("s6_sext", ADV, 0);
    check("s6_sext_imm", 128'(o_imm[sel]), 128'(32'hFFFF_8000));
    drive({6'h0d, 5'd2, 5'd3, 16'h8000}, 0, 1, 0, 1, 0, 0);
    step("s6_zext", ADV, 0);
    check("s6_zext_imm", 128'(o_imm[sel]), 128'(32'h0000_8000));

    // CNT_W=2 saturation, then an asynchronous reset in the middle of a stall.
    sel = 2;
    do_reset("s7");
    drive(enc_lw(8, 1, 16'h0050), 1, 1, 0, 0, 0, 0);
    step("s7_lw", ADV, 0);
    drive(enc_add(9, 8, 1), 0, 1, 1, 0, 0, 0);
    step("s7_bub1", BUB, 1);
    step("s7_bub2", BUB, 1);
    step("s7_bub3", BUB, 1);
    step("s7_issue", ADV, 0);
    check("s7_cnt_3", 128'(o_cnt[sel]), 128'(3));
    drive(enc_lw(8, 1, 16'h0054), 1, 1, 0, 0, 0, 0);
    step("s7_lw2", ADV, 0);
    drive(enc_add(9, 8, 1), 0, 1, 1, 0, 0, 0);
    step("s7_bub4", BUB, 1);
    check("s7_cnt_sat", 128'(o_cnt[sel]), 128'(3));
    #1;
    check("s7_pre_rst_stall", 128'(o_stall[sel]), 128'(1));
    rst_n = 1'b0;
    #1;
    check("s7_async_out", 128'(sel_out), 128'(0));
    check("s7_async_stall", 128'(o_stall[sel]), 128'(0));
    check("s7_async_cnt", 128'(o_cnt[sel]), 128'(0));
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    last_exp = '0;
    drive(enc_add(9, 8, 1), 0, 1, 1, 0, 0, 0);
    step("s7_post_rst", ADV, 0);
    check("s7_post_cnt", 128'(o_cnt[sel]), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
